stg1fq: RTL and testbench
=========================

STG1FQ -- requirements
Module: stg1fq

Interface
REQ-001 SHALL provide parameter: P_DEPTH, 4, number of queue entries; power of two, 2..16.
REQ-002 SHALL provide parameter: P_CBIT, 2, pointer width = log2(P_DEPTH); the count is P_CBIT+1 bits.
REQ-003 SHALL provide port: iw_clk  input  1  rising-edge clock.
REQ-004 SHALL provide port: iw_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port: iw_valid  input  1  fetch stage presents a fetched instruction.
REQ-006 SHALL provide port: iw_pc  input  `HBIT_ADDR+1  PC of the presented instruction.
REQ-007 SHALL provide port: iw_instr  input  `HBIT_DATA+1  presented instruction word.
REQ-008 SHALL provide port: ow_ready  output  1  queue can accept a push this cycle.
REQ-009 SHALL provide port: iw_flush  input  1  discard all queued and incoming entries (redirect).
REQ-010 SHALL provide port: ow_valid  output  1  head entry available to decode.
REQ-011 SHALL provide port: ow_pc  output  `HBIT_ADDR+1  PC of the head entry.
REQ-012 SHALL provide port: ow_instr  output  `HBIT_DATA+1  instruction word of the head entry.
REQ-013 SHALL provide port: iw_ready  input  1  decode stage accepts the head this cycle.
REQ-014 SHALL provide port: ow_count  output  P_CBIT+1  number of occupied entries.
REQ-015 SHALL provide port: ow_drop  output  1  sticky flag: an instruction was presented while the queue was full.

Function
REQ-016 SHALL operate as a circular FIFO between the fetch stage (stg1if) and decode (stg2id): write pointer, read pointer and count registers.
REQ-017 SHALL drive ow_ready = (count != P_DEPTH), depending only on registered state, with no combinational path from iw_ready.
REQ-018 SHALL push on a rising edge when iw_valid & ow_ready & !iw_flush:
- store {iw_pc, iw_instr} at the write pointer;
- increment the write pointer modulo P_DEPTH.
REQ-019 SHALL pop on a rising edge when ow_valid & iw_ready & !iw_flush, incrementing the read pointer modulo P_DEPTH.
REQ-020 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on a simultaneous push and pop.
REQ-021 SHALL drive ow_valid = (count != 0).
REQ-022 SHALL drive ow_pc and ow_instr combinationally from the entry at the read pointer when ow_valid=1, and drive both to all zeros when the queue is empty.
REQ-023 SHALL NOT bypass: a push into an empty queue appears on the outputs one cycle later (latency 1).
REQ-024 SHALL NOT accept a push when full, even if a pop occurs in the same cycle.
REQ-025 SHALL, on an edge with iw_flush=1:
- set both pointers and count to 0;
- ignore any simultaneous push or pop;
- drive ow_valid=0 in the following cycle.
REQ-026 SHALL set ow_drop on an edge where iw_valid=1, ow_ready=0 and iw_flush=0. ow_drop SHALL remain set until reset and is not cleared by a flush.
REQ-027 SHALL hold the outputs stable while ow_valid=1 and iw_ready=0.
REQ-028 SHALL handle pointer wrap-around, P_DEPTH-1 -> 0, without loss or reordering of entries.
REQ-029 SHALL leave the storage array contents unchanged when no push occurs; the array does not require reset.

Reset
REQ-030 SHALL, while iw_rst=1, asynchronously force pointers and count to 0 and ow_drop to 0. The resulting outputs SHALL be: ow_valid=0, ow_ready=1, ow_count=0, ow_pc=0, ow_instr=0.
REQ-031 SHALL, when reset is asserted mid-operation, discard all queued entries; the first push after reset deassertion lands at entry 0.
REQ-032 SHALL accept pushes starting with the first rising edge after iw_rst deasserts.

Verification
REQ-033 SHALL cover basic order with P_DEPTH=4 and iw_ready=1:
- stimulus: push PCs 0x10, 0x11, 0x12 with instrs 0xA0, 0xA1, 0xA2 on consecutive cycles;
- required: ow_pc reads 0x10, 0x11, 0x12 one cycle after each push; ow_count never exceeds 1.
REQ-034 SHALL cover full and drop:
- stimulus: iw_ready=0; present 5 valid instructions;
- required: ow_count=4, ow_ready=0 after the 4th push; the 5th is not stored; ow_drop=1; head remains PC 0x10.
REQ-035 SHALL cover a simultaneous push and pop at count=2:
- required: count stays 2; the next head is the second entry; the new entry is last in order.
REQ-036 SHALL cover flush:
- stimulus: count=3; assert iw_flush together with iw_valid=1;
- required: the next cycle shows ow_valid=0, ow_count=0, ow_instr=0; the incoming entry is discarded; ow_drop is unchanged.
REQ-037 SHALL cover wrap-around:
- stimulus: 10 push/pop pairs with PCs 0x20..0x29;
- required: output order is 0x20..0x29 with no gaps or duplicates.
REQ-038 SHALL cover reset mid-operation:
- stimulus: count=2; pulse iw_rst asynchronously between clock edges;
- required: ow_valid=0, ow_count=0, ow_drop=0 immediately; a following push of PC 0x40 appears at the head one cycle later.

Source files
------------

// File: rtl/stg1fq.sv
// rtl/stg1fq.sv - fetch-to-decode instruction queue (circular FIFO)
//
// Purpose: buffers fetched {pc, instr} pairs between fetch and decode.
// Ports:
//   iw_clk, iw_rst       clock, asynchronous active-high reset
//   iw_valid/iw_pc/iw_instr/ow_ready   push side (from fetch)
//   iw_flush             redirect: drop queued and incoming entries
//   ow_valid/ow_pc/ow_instr/iw_ready   pop side (to decode)
//   ow_count             occupied entries
//   ow_drop              sticky: a push was presented while full

`ifndef HBIT_ADDR
`define HBIT_ADDR 31
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 31
`endif

module stg1fq #(
  parameter int P_DEPTH = 4,
  parameter int P_CBIT  = 2
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_valid,
  input  logic [`HBIT_ADDR:0]   iw_pc,
  input  logic [`HBIT_DATA:0]   iw_instr,
  output logic                  ow_ready,
  input  logic                  iw_flush,
  output logic                  ow_valid,
  output logic [`HBIT_ADDR:0]   ow_pc,
  output logic [`HBIT_DATA:0]   ow_instr,
  input  logic                  iw_ready,
  output logic [P_CBIT:0]       ow_count,
  output logic                  ow_drop
);

  localparam int AW = `HBIT_ADDR + 1;
  localparam int DW = `HBIT_DATA + 1;
  localparam logic [P_CBIT:0] FULL_CNT = (P_CBIT+1)'(P_DEPTH);

  logic [AW+DW-1:0]  mem [P_DEPTH];
  logic [P_CBIT-1:0] wr_ptr;
  logic [P_CBIT-1:0] rd_ptr;
  logic [P_CBIT:0]   count;
  logic              drop;
  logic              push;
  logic              pop;

  // Handshake flags come from registered count only, so ready never
  // depends combinationally on the decode side.
  assign ow_ready = (count != FULL_CNT);
  assign ow_valid = (count != '0);
  assign ow_count = count;
  assign ow_drop  = drop;

  assign push = iw_valid & ow_ready & ~iw_flush;
  assign pop  = ow_valid & iw_ready & ~iw_flush;

  // Pointers are log2(P_DEPTH) wide, so natural overflow is the modulo wrap.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      if (iw_valid && !ow_ready && !iw_flush)
        drop <= 1'b1;
      if (iw_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + P_CBIT'(1);
        if (pop)
          rd_ptr <= rd_ptr + P_CBIT'(1);
        if (push && !pop)
          count <= count + (P_CBIT+1)'(1);
        else if (pop && !push)
          count <= count - (P_CBIT+1)'(1);
      end
    end
  end

  // Storage is not reset; only valid entries are ever observed.
  always_ff @(posedge iw_clk) begin
    if (push)
      mem[wr_ptr] <= {iw_pc, iw_instr};
  end

  always_comb begin
    ow_pc    = '0;
    ow_instr = '0;
    if (ow_valid) begin
      ow_pc    = mem[rd_ptr][AW+DW-1:DW];
      ow_instr = mem[rd_ptr][DW-1:0];
    end
  end

endmodule

// File: tb/tb_stg1fq.sv
// tb/tb_stg1fq.sv - self-checking bench for stg1fq against a queue model

`ifndef HBIT_ADDR
`define HBIT_ADDR 31
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 31
`endif

module tb_stg1fq;

  localparam int P_DEPTH = 4;
  localparam int P_CBIT  = 2;
  localparam int AW = `HBIT_ADDR + 1;
  localparam int DW = `HBIT_DATA + 1;

  logic               iw_clk = 1'b0;
  logic               iw_rst;
  logic               iw_valid;
  logic [AW-1:0]      iw_pc;
  logic [DW-1:0]      iw_instr;
  logic               ow_ready;
  logic               iw_flush;
  logic               ow_valid;
  logic [AW-1:0]      ow_pc;
  logic [DW-1:0]      ow_instr;
  logic               iw_ready;
  logic [P_CBIT:0]    ow_count;
  logic               ow_drop;

  stg1fq #(.P_DEPTH(P_DEPTH), .P_CBIT(P_CBIT)) dut (
    .iw_clk   (iw_clk),
    .iw_rst   (iw_rst),
    .iw_valid (iw_valid),
    .iw_pc    (iw_pc),
    .iw_instr (iw_instr),
    .ow_ready (ow_ready),
    .iw_flush (iw_flush),
    .ow_valid (ow_valid),
    .ow_pc    (ow_pc),
    .ow_instr (ow_instr),
    .iw_ready (iw_ready),
    .ow_count (ow_count),
    .ow_drop  (ow_drop)
  );

  always #5 iw_clk = ~iw_clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  ent_t q[$];
  bit   m_drop;
  int   total;
  int   bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] epc;
    logic [63:0] ein;
    epc = 0;
    ein = 0;
    if (q.size() != 0) begin
      epc = 64'(q[0].pc);
      ein = 64'(q[0].instr);
    end
    chk({tag, ".valid"}, 64'(ow_valid), 64'(q.size() != 0));
    chk({tag, ".ready"}, 64'(ow_ready), 64'(q.size() != P_DEPTH));
    chk({tag, ".count"}, 64'(ow_count), 64'(q.size()));
    chk({tag, ".pc"},    64'(ow_pc),    epc);
    chk({tag, ".instr"}, 64'(ow_instr), ein);
    chk({tag, ".drop"},  64'(ow_drop),  64'(m_drop));
  endtask

  // Called at a negedge: drive inputs, advance the model by the queue rules,
  // clock once, then compare at the following negedge.
  task automatic step(input string tag, input bit v, input logic [AW-1:0] pc,
                      input logic [DW-1:0] ins, input bit rdy, input bit fl);
    bit   has_room;
    bit   has_head;
    ent_t e;
    iw_valid = v;
    iw_pc    = pc;
    iw_instr = ins;
    iw_ready = rdy;
    iw_flush = fl;
    has_room = (q.size() != P_DEPTH);
    has_head = (q.size() != 0);
    e.pc     = pc;
    e.instr  = ins;
    if (v && !has_room && !fl)
      m_drop = 1'b1;
    if (fl) begin
      q.delete();
    end else begin
      if (has_head && rdy) void'(q.pop_front());
      if (v && has_room) q.push_back(e);
    end
    @(posedge iw_clk);
    @(negedge iw_clk);
    check_all(tag);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    m_drop   = 1'b0;
    iw_rst   = 1'b1;
    iw_valid = 1'b0;
    iw_pc    = '0;
    iw_instr = '0;
    iw_ready = 1'b0;
    iw_flush = 1'b0;

    // Reset state
    @(negedge iw_clk);
    check_all("reset");
    iw_rst = 1'b0;

    // Basic order with decode always ready
    for (int i = 0; i < 3; i++) begin
      step("basic", 1'b1, AW'(32'h10 + i), DW'(32'hA0 + i), 1'b1, 1'b0);
      chk("basic.head", 64'(ow_pc), 64'(32'h10 + i));
      chk("basic.cnt_le1", 64'(ow_count <= 1), 64'd1);
    end
    step("drain", 1'b0, '0, '0, 1'b1, 1'b0);

    // Fill to full, fifth push is dropped
    for (int i = 0; i < 5; i++) begin
      step("full", 1'b1, AW'(32'h10 + i), DW'(32'hB0 + i), 1'b0, 1'b0);
      if (i == 3) begin
        chk("full.count4", 64'(ow_count), 64'd4);
        chk("full.ready0", 64'(ow_ready), 64'd0);
      end
    end
    chk("full.drop", 64'(ow_drop), 64'd1);
    chk("full.head", 64'(ow_pc), 64'h10);

    // Down to two entries, then simultaneous push and pop
    step("pop", 1'b0, '0, '0, 1'b1, 1'b0);
    step("pop", 1'b0, '0, '0, 1'b1, 1'b0);
    step("simul", 1'b1, AW'(32'h50), DW'(32'hC0), 1'b1, 1'b0);
    chk("simul.count", 64'(ow_count), 64'd2);
    chk("simul.head", 64'(ow_pc), 64'h13);
    step("simul_pop", 1'b0, '0, '0, 1'b1, 1'b0);
    chk("simul.last", 64'(ow_pc), 64'h50);

    // Flush at count 3 with an incoming push
    step("fill3", 1'b1, AW'(32'h51), DW'(32'hC1), 1'b0, 1'b0);
    step("fill3", 1'b1, AW'(32'h52), DW'(32'hC2), 1'b0, 1'b0);
    chk("fill3.count", 64'(ow_count), 64'd3);
    step("flush", 1'b1, AW'(32'h60), DW'(32'hD0), 1'b0, 1'b1);
    chk("flush.valid", 64'(ow_valid), 64'd0);
    chk("flush.instr", 64'(ow_instr), 64'd0);
    chk("flush.drop", 64'(ow_drop), 64'd1);

    // Wrap-around: ten push/pop pairs
    step("wrap", 1'b1, AW'(32'h20), DW'(32'hE0), 1'b1, 1'b0);
    for (int i = 1; i < 10; i++) begin
      step("wrap", 1'b1, AW'(32'h20 + i), DW'(32'hE0 + i), 1'b1, 1'b0);
      chk("wrap.order", 64'(ow_pc), 64'(32'h20 + i));
    end
    step("wrap_end", 1'b0, '0, '0, 1'b1, 1'b0);

    // Reset mid-operation
    step("pre_rst", 1'b1, AW'(32'h30), DW'(32'hF0), 1'b0, 1'b0);
    step("pre_rst", 1'b1, AW'(32'h31), DW'(32'hF1), 1'b0, 1'b0);
    iw_valid = 1'b0;
    #2;
    iw_rst = 1'b1;
    #1;
    q.delete();
    m_drop = 1'b0;
    check_all("async_rst");
    iw_rst = 1'b0;
    @(negedge iw_clk);
    step("post_rst", 1'b1, AW'(32'h40), DW'(32'h44), 1'b0, 1'b0);
    chk("post_rst.head", 64'(ow_pc), 64'h40);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), AW'($urandom), DW'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
